pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4: cycles a multiply occupies E; legal range 1..15.
REQ-002 Parameter PERF_W, default 32: stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 dmem_miss  in  1  M-stage access missed this cycle.
REQ-006 dmem_ready  in  1  outstanding D-miss refill completes this cycle.
REQ-007 imem_ready  in  1  fetch data valid this cycle.
REQ-008 ld_use_d  in  1  load-use hazard detected in D.
REQ-009 branch_taken_e  in  1  taken branch or jump resolved in E.
REQ-010 mul_e  in  1  E holds a multiply.
REQ-011 pc_en  out  1  PC update enable.
REQ-012 en_fd, en_de, en_em, en_mw  out  1 each  enables for the F/D, D/E, E/M and M/W pipeline registers.
REQ-013 flush_fd, flush_de, flush_em, flush_mw  out  1 each  synchronous reset (bubble) for the same registers; flush overrides enable.
REQ-014 mul_done  out  1  multiply leaves E this cycle.
REQ-015 dwait  out  1  FSM in DWAIT.
REQ-016 stall_cycles  out  PERF_W  count of cycles with en_fd=0 outside reset.

Function
REQ-017 FSM states: RUN and DWAIT.
- RUN with dmem_miss=1 goes to DWAIT.
- DWAIT with dmem_ready=1 goes to RUN.
- All other cases hold state.
REQ-018 dstall = (RUN & dmem_miss) | (DWAIT & ~dmem_ready).
REQ-019 e_new register:
- Loads en_de & ~flush_de each cycle.
- mul_start = mul_e & e_new.
REQ-020 mul_cnt is a $clog2(MUL_LAT+1)-bit counter with these updates:
- Loads MUL_LAT-1 on mul_start.
- Otherwise decrements while nonzero.
- Counts regardless of dstall.
REQ-021 mbusy = (mul_start & MUL_LAT>1) | (mul_cnt>1).
REQ-022 mul_done = (mul_cnt==1) | (mul_start & MUL_LAT==1).
REQ-023 Outputs are combinational. The first matching row applies; unlisted outputs take en=1, flush=0, pc_en=1:
- dstall: pc_en=0; en_fd=en_de=en_em=0; flush_mw=1.
- mbusy: pc_en=0; en_fd=en_de=0; flush_em=1.
- branch_taken_e: flush_fd=1; flush_de=1; pc_en=1.
- ld_use_d: pc_en=0; en_fd=0; flush_de=1.
- ~imem_ready: pc_en=0; flush_fd=1.
- Otherwise: all en=1; all flush=0.
REQ-024 A branch coinciding with dstall or mbusy is not acted upon; E holds the branch, so it takes effect on the release cycle.
REQ-025 A branch coinciding with ld_use_d or ~imem_ready follows the branch row only.
REQ-026 A D-miss release occurs in the dmem_ready cycle itself: no extra bubble cycle.
REQ-027 mul_start coinciding with dstall still loads mul_cnt. If mul_cnt expires during DWAIT, mul_done pulses and no mbusy stall follows.
REQ-028 stall_cycles increments by 1 per cycle with en_fd=0 and reset=0, and saturates at all-ones.
REQ-029 dmem_miss asserted while in DWAIT is ignored.

Reset
REQ-030 While reset=1, outputs are forced as follows:
- pc_en=0; all en_*=0; all flush_*=1.
- mul_done=0.
- dwait=0 and stall_cycles=0, observed from the cycle after reset is first sampled.
REQ-031 Reset sets state to RUN, mul_cnt=0 and e_new=0, overriding any in-progress miss or multiply.
REQ-032 The first cycle after reset deasserts with idle inputs has all en=1, all flush=0 and pc_en=1.

Verification (MUL_LAT=4)
REQ-033 Reset for 2 cycles, then idle inputs with imem_ready=1:
- During reset: flush_*=1111, en_*=0000.
- Next cycle: en_*=1111, flush_*=0000, stall_cycles=0.
REQ-034 Load-use: ld_use_d=1 for 1 cycle.
- That cycle: pc_en=0, en_fd=0, flush_de=1.
- Next cycle: normal outputs; stall_cycles=1.
REQ-035 Multiply: mul_e=1 held with e_new=1.
- Cycles 1-3: en_de=0, flush_em=1.
- Cycle 4: mul_done=1, all en=1.
- stall_cycles=3.
REQ-036 D-miss: dmem_miss at cycle t, dmem_ready at t+5.
- Cycles t..t+4: en_em=0, flush_mw=1, dwait=1 from t+1.
- Cycle t+5: released.
- stall_cycles=5.
REQ-037 Simultaneous branch_taken_e=1, ld_use_d=1, imem_ready=0:
- Outputs: flush_fd=1, flush_de=1, pc_en=1, en_fd=1.
- stall_cycles unchanged.
REQ-038 Reset asserted in DWAIT with mul_cnt=2:
- Next cycle: dwait=0, mul_cnt=0.
- After reset, mul_done stays 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for a 5-stage in-order pipeline.
//
// Ports
//   clk, reset      : single clock, synchronous active-high reset
//   dmem_miss       : M-stage data access missed this cycle
//   dmem_ready      : outstanding D-miss refill completes this cycle
//   imem_ready      : fetch data valid this cycle
//   ld_use_d        : load-use hazard detected in D
//   branch_taken_e  : taken branch/jump resolved in E
//   mul_e           : E holds a multiply
//   pc_en           : PC update enable
//   en_fd/de/em/mw  : pipeline register enables
//   flush_fd/de/em/mw : pipeline register bubble inserts (override enables)
//   mul_done        : multiply leaves E this cycle
//   dwait           : FSM is waiting for a D-miss refill (exposes FSM state)
//   stall_cycles    : saturating count of cycles with en_fd=0 outside reset
//
// Handshake: a D-miss is a request/response pair. dmem_miss in RUN opens the
// transaction and dmem_ready closes it in the same cycle it is seen; a
// second dmem_miss while one is outstanding is ignored.
module pipeline_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_miss,
  input  logic              dmem_ready,
  input  logic              imem_ready,
  input  logic              ld_use_d,
  input  logic              branch_taken_e,
  input  logic              mul_e,
  output logic              pc_en,
  output logic              en_fd,
  output logic              en_de,
  output logic              en_em,
  output logic              en_mw,
  output logic              flush_fd,
  output logic              flush_de,
  output logic              flush_em,
  output logic              flush_mw,
  output logic              mul_done,
  output logic              dwait,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic L_MULTI = (MUL_LAT > 1);
  localparam logic L_SINGLE = (MUL_LAT == 1);

  typedef enum logic {S_RUN = 1'b0, S_DWAIT = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CW-1:0]     r_mul_cnt;
  logic              r_e_new;
  logic [PERF_W-1:0] r_stall_cycles;

  logic w_dstall;
  logic w_mul_start;
  logic w_mbusy;
  logic w_mul_done;

  // A multiply starts only on the first cycle a new instruction sits in E,
  // so a multiply held in E by a stall is not restarted.
  assign w_mul_start = mul_e & r_e_new;
  assign w_mbusy     = (w_mul_start & L_MULTI) | (r_mul_cnt > CW'(1));
  assign w_mul_done  = (r_mul_cnt == CW'(1)) | (w_mul_start & L_SINGLE);

  assign w_dstall = ((r_state == S_RUN) & dmem_miss) |
                    ((r_state == S_DWAIT) & ~dmem_ready);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN:   if (dmem_miss)  w_next_state = S_DWAIT;
      S_DWAIT: if (dmem_ready) w_next_state = S_RUN;
      default: w_next_state = S_RUN;
    endcase
  end

  // Priority-ordered hazard resolution. A branch under dstall/mbusy is not
  // acted upon: E is frozen, so the branch is seen again on release.
  always_comb begin
    pc_en    = 1'b1;
    en_fd    = 1'b1;
    en_de    = 1'b1;
    en_em    = 1'b1;
    en_mw    = 1'b1;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    flush_em = 1'b0;
    flush_mw = 1'b0;
    mul_done = w_mul_done & ~reset;
    if (reset) begin
      pc_en    = 1'b0;
      en_fd    = 1'b0;
      en_de    = 1'b0;
      en_em    = 1'b0;
      en_mw    = 1'b0;
      flush_fd = 1'b1;
      flush_de = 1'b1;
      flush_em = 1'b1;
      flush_mw = 1'b1;
    end else if (w_dstall) begin
      pc_en    = 1'b0;
      en_fd    = 1'b0;
      en_de    = 1'b0;
      en_em    = 1'b0;
      flush_mw = 1'b1;
    end else if (w_mbusy) begin
      pc_en    = 1'b0;
      en_fd    = 1'b0;
      en_de    = 1'b0;
      flush_em = 1'b1;
    end else if (branch_taken_e) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else if (ld_use_d) begin
      pc_en    = 1'b0;
      en_fd    = 1'b0;
      flush_de = 1'b1;
    end else if (!imem_ready) begin
      pc_en    = 1'b0;
      flush_fd = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_RUN;
      r_mul_cnt      <= '0;
      r_e_new        <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next_state;
      r_e_new <= en_de & ~flush_de;
      // The multiplier keeps counting through D-miss stalls.
      if (w_mul_start) begin
        r_mul_cnt <= CW'(MUL_LAT - 1);
      end else if (r_mul_cnt != '0) begin
        r_mul_cnt <= r_mul_cnt - CW'(1);
      end
      if (!en_fd && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
      end
    end
  end

  assign dwait        = (r_state == S_DWAIT);
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vector table plus randomized run for
// pipeline_ctrl (MUL_LAT=4), checked against a cycle-indexed reference model.
module tb_pipeline_ctrl;

  localparam int MUL_LAT = 4;
  localparam int PERF_W  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, dmem_miss, dmem_ready, imem_ready, ld_use_d, branch_taken_e, mul_e;
  logic pc_en, en_fd, en_de, en_em, en_mw;
  logic flush_fd, flush_de, flush_em, flush_mw, mul_done, dwait;
  logic [PERF_W-1:0] stall_cycles;

  pipeline_ctrl #(.MUL_LAT(MUL_LAT), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset), .dmem_miss(dmem_miss), .dmem_ready(dmem_ready),
    .imem_ready(imem_ready), .ld_use_d(ld_use_d), .branch_taken_e(branch_taken_e),
    .mul_e(mul_e), .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .en_em(en_em),
    .en_mw(en_mw), .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em),
    .flush_mw(flush_mw), .mul_done(mul_done), .dwait(dwait), .stall_cycles(stall_cycles)
  );

  // ---------------- vector table ----------------
  // inputs packed as {rst, miss, rdy, imr, lu, br, mul}
  // outputs packed as {pc_en, en_fd,en_de,en_em,en_mw, flush_fd,de,em,mw, mul_done, dwait}
  typedef struct {
    logic [6:0]        in;
    logic [10:0]       exp_o;
    logic [PERF_W-1:0] exp_st;
  } vec_t;

  vec_t tbl[$];

  localparam logic [6:0]  IDLE = 7'b0001000;
  localparam logic [6:0]  RST  = 7'b1001000;
  localparam logic [10:0] O_NORM = 11'b1_1111_0000_0_0;
  localparam logic [10:0] O_RST  = 11'b0_0000_1111_0_0;
  localparam logic [10:0] O_DST  = 11'b0_0001_0001_0_0;
  localparam logic [10:0] O_DSTW = 11'b0_0001_0001_0_1;
  localparam logic [10:0] O_MBSY = 11'b0_0011_0010_0_0;

  function automatic vec_t mk(input logic [6:0] in, input logic [10:0] o, input int st);
    vec_t v;
    v.in = in;
    v.exp_o = o;
    v.exp_st = PERF_W'(st);
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [PERF_W-1:0] act, input logic [PERF_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The multiply is tracked as the absolute cycle at which it leaves E;
  // a D-miss is tracked as a simple "refill outstanding" flag.
  longint            m_n = 0;
  longint            m_mul_end = -1;
  logic              m_wait = 1'b0;
  logic              m_enew = 1'b0;
  logic [PERF_W-1:0] m_stall = '0;

  task automatic model_step(input logic [6:0] in, output logic [10:0] o,
                            output logic [PERF_W-1:0] st);
    logic rst, miss, rdy, imr, lu, br, mul;
    logic pc, done, busy, dst, start;
    logic [3:0] en, fl;
    longint end_now;
    {rst, miss, rdy, imr, lu, br, mul} = in;
    st = m_stall;
    if (rst) begin
      o = {1'b0, 4'b0000, 4'b1111, 1'b0, m_wait};
      m_wait = 1'b0;
      m_stall = '0;
      m_enew = 1'b0;
      m_mul_end = -1;
    end else begin
      start   = mul && m_enew;
      end_now = start ? m_n + MUL_LAT - 1 : m_mul_end;
      busy    = m_n < end_now;
      done    = m_n == end_now;
      dst     = m_wait ? !rdy : miss;
      pc = 1'b1; en = 4'b1111; fl = 4'b0000;
      if (dst)       begin pc = 0; en = 4'b0001; fl = 4'b0001; end
      else if (busy) begin pc = 0; en = 4'b0011; fl = 4'b0010; end
      else if (br)   begin fl = 4'b1100; end
      else if (lu)   begin pc = 0; en = 4'b0111; fl = 4'b0100; end
      else if (!imr) begin pc = 0; fl = 4'b1000; end
      o = {pc, en, fl, done, m_wait};
      m_wait = dst;   // outstanding refill persists exactly while stalled on it
      m_enew = en[2] && !fl[2];
      m_mul_end = end_now;
      if (!en[3] && m_stall != '1) m_stall = m_stall + 1'b1;
    end
    m_n++;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [6:0] in, input logic has_tbl,
                      input logic [10:0] t_o, input logic [PERF_W-1:0] t_st,
                      input string name);
    logic [10:0] mo, act;
    logic [PERF_W-1:0] mst;
    @(negedge clk);
    {reset, dmem_miss, dmem_ready, imem_ready, ld_use_d, branch_taken_e, mul_e} = in;
    #1;
    model_step(in, mo, mst);
    exp_q.push_back(mo);
    act = {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em,
           flush_mw, mul_done, dwait};
    check({name, "_out"}, PERF_W'(act), PERF_W'(exp_q.pop_front()));
    check({name, "_stall"}, stall_cycles, mst);
    if (has_tbl) begin
      check({name, "_tbl_out"}, PERF_W'(act), PERF_W'(t_o));
      check({name, "_tbl_stall"}, stall_cycles, t_st);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, total=%0d", total);
    $fatal(1, "timeout");
  end

  // ---------------- test ----------------
  initial begin
    // reset/idle/load-use
    tbl.push_back(mk(RST,  O_RST, 0));
    tbl.push_back(mk(RST,  O_RST, 0));
    tbl.push_back(mk(IDLE, O_NORM, 0));
    tbl.push_back(mk(7'b0001100, 11'b0_0111_0100_0_0, 0));
    tbl.push_back(mk(IDLE, O_NORM, 1));
    // multiply held in E
    tbl.push_back(mk(7'b0001001, O_MBSY, 1));
    tbl.push_back(mk(7'b0001001, O_MBSY, 2));
    tbl.push_back(mk(7'b0001001, O_MBSY, 3));
    tbl.push_back(mk(7'b0001001, 11'b1_1111_0000_1_0, 4));
    tbl.push_back(mk(IDLE, O_NORM, 4));
    // D-miss, refill 5 cycles later
    tbl.push_back(mk(7'b0101000, O_DST, 4));
    tbl.push_back(mk(IDLE, O_DSTW, 5));
    tbl.push_back(mk(IDLE, O_DSTW, 6));
    tbl.push_back(mk(IDLE, O_DSTW, 7));
    tbl.push_back(mk(IDLE, O_DSTW, 8));
    tbl.push_back(mk(7'b0011000, 11'b1_1111_0000_0_1, 9));
    tbl.push_back(mk(IDLE, O_NORM, 9));
    // branch + load-use + imem not ready
    tbl.push_back(mk(7'b0000110, 11'b1_1111_1100_0_0, 9));
    tbl.push_back(mk(IDLE, O_NORM, 9));
    // multiply start under a miss, then reset in DWAIT with multiply in flight
    tbl.push_back(mk(7'b0101001, O_DST, 9));
    tbl.push_back(mk(IDLE, O_DSTW, 10));
    tbl.push_back(mk(RST, 11'b0_0000_1111_0_1, 11));
    tbl.push_back(mk(IDLE, O_NORM, 0));
    tbl.push_back(mk(IDLE, O_NORM, 0));
    tbl.push_back(mk(IDLE, O_NORM, 0));
    tbl.push_back(mk(IDLE, O_NORM, 0));
    // branch held by dstall acts on release cycle
    tbl.push_back(mk(7'b0101010, O_DST, 0));
    tbl.push_back(mk(7'b0011010, 11'b1_1111_1100_0_1, 1));
    tbl.push_back(mk(IDLE, O_NORM, 1));
    // imem not ready: en_fd stays 1, no stall count
    tbl.push_back(mk(7'b0000000, 11'b0_1111_1000_0_0, 1));
    tbl.push_back(mk(IDLE, O_NORM, 1));
    // miss while in DWAIT is ignored
    tbl.push_back(mk(7'b0101000, O_DST, 1));
    tbl.push_back(mk(7'b0111000, 11'b1_1111_0000_0_1, 2));
    tbl.push_back(mk(IDLE, O_NORM, 2));

    // initial raw reset so DUT registers are defined before checking
    @(negedge clk);
    {reset, dmem_miss, dmem_ready, imem_ready, ld_use_d, branch_taken_e, mul_e} = RST;
    @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].in, 1'b1, tbl[i].exp_o, tbl[i].exp_st, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 600; i++) begin
      logic [6:0] in;
      in[6] = ($urandom_range(0, 59) == 0);
      in[5] = ($urandom_range(0, 7) == 0);
      in[4] = ($urandom_range(0, 2) == 0);
      in[3] = ($urandom_range(0, 7) != 0);
      in[2] = ($urandom_range(0, 7) == 0);
      in[1] = ($urandom_range(0, 7) == 0);
      in[0] = ($urandom_range(0, 2) == 0);
      step(in, 1'b0, '0, '0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
